muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, meaning the number of iterative divide steps (one quotient bit per cycle); legal value is 32 only.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Start, input, 1, EX-stage request for a mult/div/move op this cycle.
REQ-005 SHALL have port Op, input, 3, opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-006 SHALL have ports A and B, input, 32 each, rs and rt operands.
REQ-007 SHALL have port Flush, input, 1, pipeline flush that aborts the in-flight op.
REQ-008 SHALL have port Busy, output, 1, high while an op is in flight; drives the pipeline stall.
REQ-009 SHALL have port Done, output, 1, one-cycle pulse when HI/LO take a mult/div result.
REQ-010 SHALL have ports ALUhi and ALUlo, output, 32 each, architectural HI and LO registers.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, DIV, FIX, DONE.
REQ-012 SHALL accept Start only in IDLE; Start outside IDLE SHALL be ignored, with no queuing.
REQ-013 SHALL handle MTHI/MTLO as follows: write A to ALUhi/ALUlo on the sampling edge, stay in IDLE, leave Busy low, leave Done low.
REQ-014 SHALL handle MULT/MULTU as IDLE->MUL->DONE->IDLE, computing the 64-bit product in MUL; {ALUhi,ALUlo} SHALL update on entry to DONE, so Done is high 2 cycles after the Start edge.
REQ-015 SHALL handle DIV/DIVU as IDLE->DIV (DIV_CYCLES cycles of restoring division on magnitudes)->FIX (sign correction)->DONE, so Done is high 34 cycles after the Start edge.
REQ-016 SHALL set signed-division signs as follows: quotient negative iff A and B signs differ; remainder takes the sign of A; ALUlo=quotient, ALUhi=remainder.
REQ-017 SHALL handle divide by zero by completing with full latency, giving ALUlo=32'hFFFFFFFF and ALUhi=A.
REQ-018 SHALL handle 32'h80000000 / -1 (signed) with ALUlo=32'h80000000 and ALUhi=0.
REQ-019 SHALL drive Busy high in MUL, DIV and FIX, and low in IDLE and DONE.
REQ-020 SHALL latch operands and Op at Start, so later changes on A/B/Op have no effect.
REQ-021 SHALL handle Flush in any non-IDLE state by returning to IDLE next edge, leaving HI/LO unchanged and not pulsing Done; Flush in DONE SHALL NOT undo an already-written HI/LO.
REQ-022 SHALL give Flush priority over Start when both are asserted in IDLE; neither the op nor MTHI/MTLO takes effect.
REQ-023 SHALL permit a new Start in the DONE cycle to be ignored; the earliest next accept is the following IDLE cycle.

Reset
REQ-024 SHALL, while Reset=0, asynchronously force state IDLE, ALUhi=0, ALUlo=0, Busy=0, Done=0, and clear the internal iteration counter and latched operands.
REQ-025 SHALL discard an in-flight op when Reset asserts mid-operation; after release the unit SHALL accept Start on the first edge.

Configuration
REQ-026 SHALL, with macro MULDIV_MADD_EN defined, implement MADD/MSUB as {ALUhi,ALUlo} +/- signed(A*B), 64-bit wrap-around, using MUL timing.
REQ-027 SHALL, without MULDIV_MADD_EN, treat Op 6/7 as no-ops: no state change, Busy low, HI/LO unchanged.

Structure
REQ-028 SHALL place the Op encodings, FSM state encodings and DIV_CYCLES default in shared package muldiv_pkg.
REQ-029 SHALL contain one sub-module, div_step: combinational single restoring-division step (partial remainder, divisor -> next remainder, quotient bit), instantiated once.

Verification
REQ-030 SHALL verify MULT A=-3, B=7: Done 2 cycles after Start, ALUhi=32'hFFFFFFFF, ALUlo=32'hFFFFFFEB.
REQ-031 SHALL verify DIV A=-7, B=2: Busy 33 cycles, Done at cycle 34, ALUlo=32'hFFFFFFFD, ALUhi=32'hFFFFFFFF.
REQ-032 SHALL verify DIVU A=5, B=0: ALUlo=32'hFFFFFFFF, ALUhi=5, full latency.
REQ-033 SHALL verify DIVU started, Flush at cycle 10: Busy drops next cycle, Done never pulses, HI/LO keep prior values.
REQ-034 SHALL verify Reset=0 asserted mid-DIV: outputs zero immediately without a clock; after release, MTLO A=32'h1234 gives ALUlo=32'h1234 next edge.
REQ-035 SHALL verify, with MULDIV_MADD_EN, HI/LO=0:10 then MADD A=3, B=4: ALUlo=22, ALUhi=0; without the macro, HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, FSM states
// and the default iterative divide length.
package muldiv_pkg;

  localparam int unsigned DIV_CYCLES_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and emit the resulting quotient bit.
module div_step (
  input  logic [31:0] rem,
  input  logic        bit_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        q
);

  logic [32:0] partial;

  always_comb begin
    partial  = {rem, bit_in};
    q        = (partial >= {1'b0, divisor});
    rem_next = q ? 32'(partial - {1'b0, divisor}) : partial[31:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit with an iterative restoring divider.
// Define MULDIV_MADD_EN to enable MADD/MSUB (otherwise Op 6/7 are no-ops).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] ALUhi,
  output logic [31:0] ALUlo
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  state_e           state, state_next;
  op_e              op_in, op_q;
  logic [31:0]      a_q, b_q, hi_q, lo_q;
  logic [31:0]      rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;

  logic             start_ok, in_mul, in_div, in_madd, in_sdiv, cnt_last;
  logic [31:0]      a_mag, b_mag, step_rem, fix_hi, fix_lo;
  logic             step_q, sdiv_q;
  logic [63:0]      a_ext, b_ext, prod, mul_res;

  assign op_in = op_e'(Op);

  // Input decode and operand magnitudes captured at accept time
  always_comb begin
    start_ok = Start && !Flush;
`ifdef MULDIV_MADD_EN
    in_madd  = (op_in == OP_MADD) || (op_in == OP_MSUB);
`else
    in_madd  = 1'b0;
`endif
    in_mul   = (op_in == OP_MULT) || (op_in == OP_MULTU) || in_madd;
    in_div   = (op_in == OP_DIV) || (op_in == OP_DIVU);
    in_sdiv  = (op_in == OP_DIV);
    a_mag    = (in_sdiv && A[31]) ? neg32(A) : A;
    b_mag    = (in_sdiv && B[31]) ? neg32(B) : B;
  end

  assign cnt_last = (cnt_q == CNT_W'(DIV_CYCLES - 1));

  // FSM: state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_ok && in_mul)      state_next = ST_MUL;
        else if (start_ok && in_div) state_next = ST_DIV;
      end
      ST_MUL:  state_next = Flush ? ST_IDLE : ST_DONE;
      ST_DIV:  state_next = Flush ? ST_IDLE : (cnt_last ? ST_FIX : ST_DIV);
      ST_FIX:  state_next = Flush ? ST_IDLE : ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    Busy = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
    Done = (state == ST_DONE);
  end

  // Multiply path; MADD/MSUB accumulate onto the current HI/LO pair
  always_comb begin
    a_ext   = (op_q == OP_MULTU) ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
    b_ext   = (op_q == OP_MULTU) ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
    prod    = a_ext * b_ext;
    mul_res = prod;
`ifdef MULDIV_MADD_EN
    if (op_q == OP_MADD)      mul_res = {hi_q, lo_q} + prod;
    else if (op_q == OP_MSUB) mul_res = {hi_q, lo_q} - prod;
`endif
  end

  div_step u_div_step (
    .rem      (rem_q),
    .bit_in   (quo_q[31]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q        (step_q)
  );

  // Sign fix-up; divide-by-zero is special-cased since magnitudes lose A's sign
  always_comb begin
    sdiv_q = (op_q == OP_DIV);
    if (b_q == '0) begin
      fix_lo = '1;
      fix_hi = a_q;
    end else begin
      fix_lo = (sdiv_q && (a_q[31] ^ b_q[31])) ? neg32(quo_q) : quo_q;
      fix_hi = (sdiv_q && a_q[31]) ? neg32(rem_q) : rem_q;
    end
  end

  // Datapath registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      op_q  <= OP_MULT;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            op_q  <= op_in;
            a_q   <= A;
            b_q   <= B;
            rem_q <= '0;
            quo_q <= a_mag;
            dvs_q <= b_mag;
            cnt_q <= '0;
            if (op_in == OP_MTHI) hi_q <= A;
            if (op_in == OP_MTLO) lo_q <= A;
          end
        end
        ST_MUL: begin
          if (!Flush) {hi_q, lo_q} <= mul_res;
        end
        ST_DIV: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[30:0], step_q};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        ST_FIX: begin
          if (!Flush) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign ALUhi = hi_q;
  assign ALUlo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO and due cycle,
// a negedge monitor pops and compares on every Done pulse.
module tb_muldiv_unit;

`ifdef MULDIV_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        Clk, Reset, Start, Flush, Busy, Done;
  logic [2:0]  Op;
  logic [31:0] A, B, ALUhi, ALUlo;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  muldiv_unit #(.DIV_CYCLES(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .Busy(Busy), .Done(Done), .ALUhi(ALUhi), .ALUlo(ALUlo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
    longint          sp;
    longint unsigned up;
    int              q, r;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = 64'(a) * 64'(b);
    case (op)
      3'd0: return sp;
      3'd1: return up;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      3'd3: return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      3'd6: return {hi, lo} + sp;
      3'd7: return {hi, lo} - sp;
      default: return {hi, lo};
    endcase
  endfunction

  function automatic bit is_result_op(input logic [2:0] op);
    return (op <= 3'd3) || (MADD_EN && op >= 3'd6);
  endfunction

  function automatic int latency(input logic [2:0] op);
    return (op == 3'd2 || op == 3'd3) ? 34 : 2;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, input bit track);
    exp_t e;
    Start = 1'b1; Op = op; A = a; B = b;
    if (track) begin
      if (is_result_op(op)) begin
        e.res = model(op, a, b, m_hi, m_lo);
        e.due = cyc + latency(op);
        sb.push_back(e);
        {m_hi, m_lo} = e.res;
      end else if (op == 3'd4) m_hi = a;
      else if (op == 3'd5) m_lo = a;
    end
    step();
    Start = 1'b0; Op = 3'($urandom); A = $urandom; B = $urandom;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || Busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=%0d cycles required<%0d", name, n, budget);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation
  always @(negedge Clk) begin
    if (Reset && Done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_hi", 64'(ALUhi), 64'(mon_e.res[63:32]));
        chk("done_lo", 64'(ALUlo), 64'(mon_e.res[31:0]));
        chk("done_latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [2:0]  op;
    logic [31:0] a, b;
    Reset = 1'b0; Start = 1'b0; Flush = 1'b0; Op = '0; A = '0; B = '0;
    #12;
    chk("reset_hi", 64'(ALUhi), 64'h0);
    chk("reset_lo", 64'(ALUlo), 64'h0);
    chk("reset_busy", 64'(Busy), 64'h0);
    chk("reset_done", 64'(Done), 64'h0);
    @(posedge Clk); #2 Reset = 1'b1;
    step();

    // MULT -3*7; Start held through MUL and DONE must be ignored
    issue(3'd0, 32'hFFFFFFFD, 32'd7, 1'b1);
    Start = 1'b1; Op = 3'd4; A = 32'hCAFE0000;
    step(); step();
    Start = 1'b0;
    wait_quiet("mult", 10);
    chk("mult_hi", 64'(ALUhi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(ALUlo), 64'hFFFFFFEB);

    // DIV -7/2 with Busy length and an ignored mid-op MTLO
    issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1);
    n = 0;
    while (Busy && n < 100) begin
      n++;
      if (n == 5) begin Start = 1'b1; Op = 3'd5; A = 32'hDEAD; end
      if (n == 6) Start = 1'b0;
      step();
    end
    chk("div_busy_cycles", 64'(n), 64'd33);
    wait_quiet("div", 10);
    chk("div_lo", 64'(ALUlo), 64'hFFFFFFFD);
    chk("div_hi", 64'(ALUhi), 64'hFFFFFFFF);

    issue(3'd3, 32'd5, 32'd0, 1'b1);
    wait_quiet("divu_zero", 50);
    chk("divu_zero_lo", 64'(ALUlo), 64'hFFFFFFFF);
    chk("divu_zero_hi", 64'(ALUhi), 64'd5);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_quiet("div_ovf", 50);
    chk("div_ovf_lo", 64'(ALUlo), 64'h80000000);
    chk("div_ovf_hi", 64'(ALUhi), 64'h0);

    // Flush at cycle 10 of a DIVU
    issue(3'd3, $urandom, 32'd3, 1'b0);
    repeat (9) step();
    chk("flush_busy_before", 64'(Busy), 64'h1);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("flush_busy_after", 64'(Busy), 64'h0);
    repeat (40) step();
    chk("flush_hi", 64'(ALUhi), 64'(m_hi));
    chk("flush_lo", 64'(ALUlo), 64'(m_lo));

    // Flush beats Start in IDLE
    Flush = 1'b1;
    issue(3'd5, 32'h5555, 32'h0, 1'b0);
    Flush = 1'b0;
    chk("flush_start_lo", 64'(ALUlo), 64'(m_lo));
    chk("flush_start_busy", 64'(Busy), 64'h0);

    // Async reset mid-DIV, then MTLO on the first edge after release
    issue(3'd2, $urandom, 32'd7, 1'b1);
    repeat (5) step();
    #2 Reset = 1'b0;
    #1;
    chk("midreset_hi", 64'(ALUhi), 64'h0);
    chk("midreset_lo", 64'(ALUlo), 64'h0);
    chk("midreset_busy", 64'(Busy), 64'h0);
    chk("midreset_done", 64'(Done), 64'h0);
    sb.delete();
    m_hi = '0; m_lo = '0;
    @(posedge Clk); #3 Reset = 1'b1;
    issue(3'd5, 32'h1234, 32'h0, 1'b1);
    chk("post_reset_mtlo", 64'(ALUlo), 64'h1234);
    chk("post_reset_busy", 64'(Busy), 64'h0);

    // MADD 3*4 onto HI/LO = 0:10
    issue(3'd4, 32'h0, 32'h0, 1'b1);
    issue(3'd5, 32'd10, 32'h0, 1'b1);
    issue(3'd6, 32'd3, 32'd4, 1'b1);
    if (MADD_EN) begin
      wait_quiet("madd", 10);
      chk("madd_lo", 64'(ALUlo), 64'd22);
      chk("madd_hi", 64'(ALUhi), 64'd0);
    end else begin
      chk("madd_off_busy", 64'(Busy), 64'h0);
      repeat (3) step();
      chk("madd_off_lo", 64'(ALUlo), 64'd10);
      chk("madd_off_hi", 64'(ALUhi), 64'd0);
    end

    // Randomized mix
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a = rand_opnd();
      b = rand_opnd();
      issue(op, a, b, 1'b1);
      if (is_result_op(op)) begin
        wait_quiet("rand_op", 50);
      end else begin
        chk("rand_idle_busy", 64'(Busy), 64'h0);
        chk("rand_idle_hilo", {ALUhi, ALUlo}, {m_hi, m_lo});
      end
    end

    repeat (5) step();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
